// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - two-requester round-robin APB master (optional watchdog: APB_ARB_TIMEOUT_EN)
module apb_arb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] req_rdata,
  output logic                  req_err,
  output logic [3:0]            psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  gnt_q, gnt_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  timeout;
  logic                  done;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts earlier stalled ACCESS cycles, so the current one is cnt_q+1
  assign timeout = (state_q == ACCESS) && !pready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !pready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign done = (state_q == ACCESS) && (pready || timeout);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // req1 wins only alone or when req0 held the previous grant
          gnt_d   = req1_valid && (!req0_valid || !last_q);
          last_d  = gnt_d;
          write_d = gnt_d ? req1_write : req0_write;
          addr_d  = gnt_d ? req1_addr  : req0_addr;
          wdata_d = gnt_d ? req1_wdata : req0_wdata;
          state_d = SETUP;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    psel = '0;
    if (state_q != IDLE) begin
      psel[addr_q[ADDR_WIDTH-1:ADDR_WIDTH-2]] = 1'b1;
    end
  end

  assign penable    = (state_q == ACCESS);
  assign paddr      = addr_q;
  assign pwrite     = write_q;
  assign pwdata     = wdata_q;
  assign req0_ready = done && !gnt_q;
  assign req1_ready = done && gnt_q;
  assign req_rdata  = (done && !write_q && !timeout) ? prdata : '0;
  assign req_err    = timeout;

endmodule

// File: tb/tb_apb_arb_master.sv
// tb/tb_apb_arb_master.sv - scoreboard bench for apb_arb_master
module tb_apb_arb_master;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [7:0]  req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [7:0]  req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req0_ready, req1_ready, req_err, penable, pwrite;
  logic [31:0] req_rdata, pwdata;
  logic [3:0]  psel;
  logic [7:0]  paddr;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int stall_cfg = 0;
  int acc_cnt = 0;
  logic [31:0] slave_rdata = '0;

  typedef struct {bit who; logic [31:0] rdata; bit err;} exp_t;
  exp_t exp_q[$];

  apb_arb_master dut (
    .clk(clk), .arst_n(arst_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .req_rdata(req_rdata), .req_err(req_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [7:0] a);
    return 4'b0001 << a[7:6];
  endfunction

  // Slave: pready rises after stall_cfg stalled ACCESS cycles
  always @(posedge clk) begin
    #1;
    if (penable) begin
      pready = (acc_cnt >= stall_cfg);
      acc_cnt++;
    end else begin
      pready = 1'b0;
      acc_cnt = 0;
    end
    prdata = slave_rdata;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (arst_n && (req0_ready || req1_ready)) begin
      exp_t e;
      chk("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_who", {63'd0, req1_ready}, {63'd0, e.who});
        chk("sb_rdata", {32'd0, req_rdata}, {32'd0, e.rdata});
        chk("sb_err", {63'd0, req_err}, {63'd0, e.err});
      end
    end
  end

  task automatic xfer(input bit who, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int stall, input int exp_lat, input bit exp_err);
    exp_t e;
    int n;
    e.who = who; e.err = exp_err; e.rdata = (wr || exp_err) ? 32'd0 : rd;
    exp_q.push_back(e);
    stall_cfg = stall; slave_rdata = rd;
    @(posedge clk); #1;
    if (who) begin
      req1_valid = 1; req1_write = wr; req1_addr = a; req1_wdata = wd;
    end else begin
      req0_valid = 1; req0_write = wr; req0_addr = a; req0_wdata = wd;
    end
    n = 0;
    while (1) begin
      @(negedge clk); n++;
      if (n == 1) chk("idle_psel", {60'd0, psel}, 64'd0);
      if (n >= 2) begin
        chk("psel", {60'd0, psel}, {60'd0, onehot(a)});
        chk("paddr", {56'd0, paddr}, {56'd0, a});
        chk("pwrite", {63'd0, pwrite}, {63'd0, wr});
        chk("pwdata", {32'd0, pwdata}, {32'd0, wd});
        chk("penable", {63'd0, penable}, {63'd0, n >= 3});
      end
      if (req0_ready || req1_ready) begin
        chk("latency", n, exp_lat);
        break;
      end
      if (n > 60) begin
        chk("ready_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("post_idle_psel", {60'd0, psel}, 64'd0);
    chk("post_idle_penable", {63'd0, penable}, 64'd0);
    chk("post_idle_paddr_hold", {56'd0, paddr}, {56'd0, a});
  endtask

  initial begin
    int n, got;
    exp_t e;
    #2;
    chk("rst_psel", {60'd0, psel}, 64'd0);
    chk("rst_penable", {63'd0, penable}, 64'd0);
    chk("rst_paddr", {56'd0, paddr}, 64'd0);
    chk("rst_pwdata", {32'd0, pwdata}, 64'd0);
    chk("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    chk("rst_rdata", {32'd0, req_rdata}, 64'd0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1;

    xfer(0, 1, 8'h45, 32'hDEADBEEF, 32'h0, 0, 3, 0);
    xfer(1, 0, 8'hC0, 32'h0, 32'h12345678, 0, 3, 0);
    xfer(0, 0, 8'h83, 32'h0, 32'hCAFEF00D, 5, 8, 0);
`ifdef APB_ARB_TIMEOUT_EN
    xfer(1, 0, 8'h10, 32'h0, 32'hAAAA5555, 1000, 18, 1);
`endif

    // Reset during ACCESS aborts without a ready pulse
    stall_cfg = 100;
    @(posedge clk); #1;
    req1_valid = 1; req1_write = 0; req1_addr = 8'h80;
    repeat (3) @(negedge clk);
    chk("pre_rst_penable", {63'd0, penable}, 64'd1);
    #2 arst_n = 0;
    #1;
    chk("abort_psel", {60'd0, psel}, 64'd0);
    chk("abort_penable", {63'd0, penable}, 64'd0);
    chk("abort_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    chk("abort_paddr", {56'd0, paddr}, 64'd0);
    req1_valid = 0;
    @(posedge clk); #1 arst_n = 1;

    // Continuous contention: req0 first after reset, then alternate
    stall_cfg = 0; slave_rdata = 32'h0BADCAFE;
    for (int i = 0; i < 4; i++) begin
      e.who = i[0]; e.err = 0; e.rdata = i[0] ? 32'h0BADCAFE : 32'd0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req0_valid = 1; req0_write = 1; req0_addr = 8'h04; req0_wdata = 32'h11111111;
    req1_valid = 1; req1_write = 0; req1_addr = 8'h48;
    n = 0; got = 0;
    while (got < 4 && n < 40) begin
      @(negedge clk); n++;
      if (n % 3 == 1) chk("rr_idle_psel", {60'd0, psel}, 64'd0);
      if (req0_ready || req1_ready) begin
        chk("rr_cycle", n, 3 * (got + 1));
        got++;
      end
    end
    chk("rr_count", got, 4);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;

    repeat (4) @(posedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
